vga_text_engine: RTL

VGA_TEXT_ENGINE -- requirements
Module: vga_text_engine

---
 rtl/vga_text_engine.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vga_text_engine.sv
// vga_text_engine: 80x60-cell style text-mode VGA raster with attribute colours, blink and underline cursor
module vga_text_engine #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_BITS     = 10,
    parameter int V_BITS     = 10,
    parameter int CLK_DIV    = 2,
    parameter int COLOR_BITS = 4,
    parameter bit SYNC_POL   = 1'b0,
    parameter int BLINK_LOG2 = 5
) (
    input  logic                     CLK_50M,
    input  logic                     RST,
    input  logic                     CURSOR_EN,
    input  logic [H_BITS-4:0]        CURSOR_X,
    input  logic [V_BITS-4:0]        CURSOR_Y,
    output logic                     ROM_CE,
    output logic [H_BITS+V_BITS-7:0] MAP_ADDR,
    input  logic [7:0]               MAP_DATA,
    input  logic [7:0]               ATTR_DATA,
    output logic [10:0]              CHAR_ADDR,
    input  logic [7:0]               CHAR_DATA,
    output logic [COLOR_BITS-1:0]    VGA_R,
    output logic [COLOR_BITS-1:0]    VGA_G,
    output logic [COLOR_BITS-1:0]    VGA_B,
    output logic                     VGA_HSYNC,
    output logic                     VGA_VSYNC,
    output logic                     VGA_DE,
    output logic                     FRAME_START
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [H_BITS-1:0] H_LAST   = H_BITS'(H_TOTAL - 1);
    localparam logic [H_BITS-1:0] H_VIS    = H_BITS'(H_ACTIVE);
    localparam logic [H_BITS-1:0] HS_BEG   = H_BITS'(H_ACTIVE + H_FP);
    localparam logic [H_BITS-1:0] HS_END   = H_BITS'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_BITS-1:0] V_LAST   = V_BITS'(V_TOTAL - 1);
    localparam logic [V_BITS-1:0] V_VIS    = V_BITS'(V_ACTIVE);
    localparam logic [V_BITS-1:0] VS_BEG   = V_BITS'(V_ACTIVE + V_FP);
    localparam logic [V_BITS-1:0] VS_END   = V_BITS'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0]      div;
    logic                  ce;
    logic [H_BITS-1:0]     hcount, hcount_d1, hcount_d2;
    logic [V_BITS-1:0]     vcount, vcount_d1, vcount_d2;
    logic                  cur_hit, cur_d1, cur_d2;
    logic                  valid_d1, valid_d2;
    logic [7:0]            attr_d2;
    logic [BLINK_LOG2-1:0] frame_cnt;
    logic                  phase, pixel, active, hs_on, vs_on, unused_attr;
    logic [2:0]            fg, bg, col;

    always_comb begin
        ce          = div == DIV_LAST;
        ROM_CE      = ce;
        MAP_ADDR    = {vcount[V_BITS-1:3], hcount[H_BITS-1:3]};
        CHAR_ADDR   = {MAP_DATA, vcount_d1[2:0]};
        cur_hit     = CURSOR_EN && hcount[H_BITS-1:3] == CURSOR_X &&
                      vcount[V_BITS-1:3] == CURSOR_Y && vcount[2:0] == 3'd7;
        phase       = frame_cnt[BLINK_LOG2-1];
        pixel       = CHAR_DATA[3'd7 - hcount_d2[2:0]] | (cur_d2 & ~phase);
        bg          = attr_d2[6:4];
        fg          = (attr_d2[7] && phase) ? bg : attr_d2[2:0];
        col         = pixel ? fg : bg;
        unused_attr = attr_d2[3];
        // valid_d2 keeps reset-cleared pipeline contents from ever being displayed
        active      = valid_d2 && hcount_d2 < H_VIS && vcount_d2 < V_VIS;
        hs_on       = valid_d2 && hcount_d2 >= HS_BEG && hcount_d2 <= HS_END;
        vs_on       = valid_d2 && vcount_d2 >= VS_BEG && vcount_d2 <= VS_END;
    end

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            div         <= '0;
            hcount      <= '0;
            vcount      <= '0;
            hcount_d1   <= '0;
            vcount_d1   <= '0;
            hcount_d2   <= '0;
            vcount_d2   <= '0;
            cur_d1      <= 1'b0;
            cur_d2      <= 1'b0;
            valid_d1    <= 1'b0;
            valid_d2    <= 1'b0;
            attr_d2     <= '0;
            frame_cnt   <= '0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_DE      <= 1'b0;
            VGA_HSYNC   <= ~SYNC_POL;
            VGA_VSYNC   <= ~SYNC_POL;
            FRAME_START <= 1'b0;
        end else begin
            div         <= ce ? '0 : div + 1'b1;
            FRAME_START <= ce && valid_d2 && hcount_d2 == '0 && vcount_d2 == '0;
            if (ce) begin
                hcount    <= hcount == H_LAST ? '0 : hcount + 1'b1;
                if (hcount == H_LAST)
                    vcount <= vcount == V_LAST ? '0 : vcount + 1'b1;
                if (hcount == H_LAST && vcount == V_LAST)
                    frame_cnt <= frame_cnt + 1'b1;
                hcount_d1 <= hcount;
                vcount_d1 <= vcount;
                cur_d1    <= cur_hit;
                valid_d1  <= 1'b1;
                hcount_d2 <= hcount_d1;
                vcount_d2 <= vcount_d1;
                cur_d2    <= cur_d1;
                valid_d2  <= valid_d1;
                attr_d2   <= ATTR_DATA;
                VGA_R     <= active ? {COLOR_BITS{col[2]}} : '0;
                VGA_G     <= active ? {COLOR_BITS{col[1]}} : '0;
                VGA_B     <= active ? {COLOR_BITS{col[0]}} : '0;
                VGA_DE    <= active;
                VGA_HSYNC <= hs_on ? SYNC_POL : ~SYNC_POL;
                VGA_VSYNC <= vs_on ? SYNC_POL : ~SYNC_POL;
            end
        end
    end
endmodule
